// File: rtl/frame_serializer_pkg.sv
// Shared types and helpers for the frame serializer: FSM state encoding and
// the payload-length clamp applied at load time.
package frame_serializer_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    // A zero or oversized length means "send the full word".
    function automatic int unsigned clamp_len(input int unsigned len, input int unsigned max_w);
        if (len == 0 || len > max_w) begin
            return max_w;
        end
        return len;
    endfunction

endpackage

// File: rtl/ser_parity.sv
// Masked XOR reduction: parity of data bits [len-1:0]; bits at or above len
// are ignored.
module ser_parity #(
    parameter int MAX_WIDTH = 8,
    parameter int LEN_W     = $clog2(MAX_WIDTH) + 1
) (
    input  logic [MAX_WIDTH-1:0] data,
    input  logic [LEN_W-1:0]     len,
    output logic                 parity
);

    always_comb begin
        parity = 1'b0;
        for (int i = 0; i < MAX_WIDTH; i++) begin
            if (i < 32'(len)) begin
                parity = parity ^ data[i];
            end
        end
    end

endmodule

// File: rtl/frame_serializer.sv
// Parallel-to-serial frame shifter with selectable bit order, parity output,
// abort and zero-gap back-to-back loading.
//
// Handshake: a load happens on any rising edge where Ready=1, Data_valid=1
// and Abort=0; Data_valid while Ready=0 is ignored and needs no hold. Ser_EN
// advances one bit per strobe in SHIFT only; Abort wins over everything else.
module frame_serializer
    import frame_serializer_pkg::*;
#(
    parameter int MAX_WIDTH = 8,
    parameter int LEN_W     = $clog2(MAX_WIDTH) + 1
) (
    input  logic                 CLK,
    input  logic                 Reset,
    input  logic [MAX_WIDTH-1:0] Data,
    input  logic [LEN_W-1:0]     Data_len,
    input  logic                 MSB_first,
    input  logic                 Par_type,
    input  logic                 Data_valid,
    input  logic                 Ser_EN,
    input  logic                 Abort,
    output logic                 Ready,
    output logic                 Busy,
    output logic                 Ser_data,
    output logic                 Ser_done,
    output logic                 Par_bit,
    output state_t               fsm_state
);

    state_t               state, state_n;
    logic [MAX_WIDTH-1:0] shift_reg, shift_n;
    logic [LEN_W-1:0]     len_r, len_n;
    logic [LEN_W-1:0]     cnt, cnt_n;
    logic                 msb_r, msb_n;
    logic                 ser_r, ser_n;
    logic                 done_r, done_n;
    logic                 par_r, par_n;

    logic [LEN_W-1:0]     load_len;
    logic [MAX_WIDTH-1:0] load_mask;
    logic [MAX_WIDTH-1:0] load_data;
    logic                 load_par;
    logic                 first_bit;
    logic                 next_bit;

    function automatic logic pick_bit(input logic [MAX_WIDTH-1:0] v, input logic [LEN_W-1:0] idx);
        logic b;
        b = 1'b0;
        for (int i = 0; i < MAX_WIDTH; i++) begin
            if (i == 32'(idx)) begin
                b = v[i];
            end
        end
        return b;
    endfunction

    always_comb begin
        load_len = LEN_W'(clamp_len(32'(Data_len), MAX_WIDTH));
        for (int i = 0; i < MAX_WIDTH; i++) begin
            load_mask[i] = (i < 32'(load_len));
        end
        load_data = Data & load_mask;
    end

    ser_parity #(
        .MAX_WIDTH (MAX_WIDTH),
        .LEN_W     (LEN_W)
    ) u_parity (
        .data   (Data),
        .len    (load_len),
        .parity (load_par)
    );

    // cnt counts bits already presented; the next index follows from it
    // directly, so the captured word itself never changes during a frame.
    always_comb begin
        first_bit = pick_bit(load_data, MSB_first ? (load_len - LEN_W'(1)) : '0);
        next_bit  = pick_bit(shift_reg, msb_r ? (len_r - cnt - LEN_W'(1)) : cnt);
    end

    always_comb begin
        state_n = state;
        shift_n = shift_reg;
        len_n   = len_r;
        msb_n   = msb_r;
        cnt_n   = cnt;
        ser_n   = ser_r;
        done_n  = 1'b0;
        par_n   = par_r;
        if (Abort) begin
            state_n = IDLE;
            ser_n   = 1'b0;
            cnt_n   = '0;
        end else begin
            case (state)
                IDLE: begin
                    if (Data_valid) begin
                        state_n = SHIFT;
                        shift_n = load_data;
                        len_n   = load_len;
                        msb_n   = MSB_first;
                        cnt_n   = LEN_W'(1);
                        ser_n   = first_bit;
                        par_n   = load_par ^ Par_type;
                    end
                end
                SHIFT: begin
                    if (Ser_EN) begin
                        if (cnt < len_r) begin
                            ser_n = next_bit;
                            cnt_n = cnt + LEN_W'(1);
                        end else begin
                            state_n = IDLE;
                            ser_n   = 1'b0;
                            cnt_n   = '0;
                            done_n  = 1'b1;
                        end
                    end
                end
                default: begin
                    state_n = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            state     <= IDLE;
            shift_reg <= '0;
            len_r     <= '0;
            msb_r     <= 1'b0;
            cnt       <= '0;
            ser_r     <= 1'b0;
            done_r    <= 1'b0;
            par_r     <= 1'b0;
        end else begin
            state     <= state_n;
            shift_reg <= shift_n;
            len_r     <= len_n;
            msb_r     <= msb_n;
            cnt       <= cnt_n;
            ser_r     <= ser_n;
            done_r    <= done_n;
            par_r     <= par_n;
        end
    end

    assign Ready     = (state == IDLE);
    assign Busy      = (state == SHIFT);
    assign Ser_data  = ser_r;
    assign Ser_done  = done_r;
    assign Par_bit   = par_r;
    assign fsm_state = state;

endmodule

// File: tb/tb_frame_serializer.sv
// Bench for frame_serializer: queue-based frame model checked every cycle,
// directed frames with literal bit sequences, then randomized traffic.
module tb_frame_serializer;
    import frame_serializer_pkg::*;

    localparam int MAX_WIDTH = 8;
    localparam int LEN_W     = 4;

    logic                 CLK = 1'b0;
    logic                 Reset;
    logic [MAX_WIDTH-1:0] Data;
    logic [LEN_W-1:0]     Data_len;
    logic                 MSB_first, Par_type, Data_valid, Ser_EN, Abort;
    logic                 Ready, Busy, Ser_data, Ser_done, Par_bit;
    state_t               fsm_state;

    int n_checks = 0;
    int n_fail   = 0;

    frame_serializer #(.MAX_WIDTH(MAX_WIDTH), .LEN_W(LEN_W)) dut (
        .CLK        (CLK),
        .Reset      (Reset),
        .Data       (Data),
        .Data_len   (Data_len),
        .MSB_first  (MSB_first),
        .Par_type   (Par_type),
        .Data_valid (Data_valid),
        .Ser_EN     (Ser_EN),
        .Abort      (Abort),
        .Ready      (Ready),
        .Busy       (Busy),
        .Ser_data   (Ser_data),
        .Ser_done   (Ser_done),
        .Par_bit    (Par_bit),
        .fsm_state  (fsm_state)
    );

    // clock / reset
    always #5 CLK = ~CLK;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // behavioural model: a frame is a queue of bits still to be presented
    bit m_busy = 1'b0;
    bit m_ser  = 1'b0;
    bit m_done = 1'b0;
    bit m_par  = 1'b0;
    bit m_bits[$];

    always @(posedge CLK or negedge Reset) begin
        int l;
        int ones;
        if (!Reset) begin
            m_busy = 1'b0;
            m_ser  = 1'b0;
            m_done = 1'b0;
            m_par  = 1'b0;
            m_bits.delete();
        end else begin
            m_done = 1'b0;
            if (Abort) begin
                m_busy = 1'b0;
                m_ser  = 1'b0;
                m_bits.delete();
            end else if (!m_busy) begin
                if (Data_valid) begin
                    l = (Data_len == 0 || int'(Data_len) > MAX_WIDTH) ? MAX_WIDTH : int'(Data_len);
                    ones = 0;
                    m_bits.delete();
                    for (int k = 0; k < l; k++) begin
                        m_bits.push_back(Data[MSB_first ? (l - 1 - k) : k]);
                        ones += int'(Data[k]);
                    end
                    m_par  = bit'(ones % 2) ^ Par_type;
                    m_ser  = m_bits.pop_front();
                    m_busy = 1'b1;
                end
            end else if (Ser_EN) begin
                if (m_bits.size() > 0) begin
                    m_ser = m_bits.pop_front();
                end else begin
                    m_busy = 1'b0;
                    m_ser  = 1'b0;
                    m_done = 1'b1;
                end
            end
        end
    end

    // compare process
    always @(negedge CLK) begin
        check("ready",    32'(Ready),     32'(!m_busy));
        check("busy",     32'(Busy),      32'(m_busy));
        check("ser_data", 32'(Ser_data),  32'(m_ser));
        check("ser_done", 32'(Ser_done),  32'(m_done));
        check("par_bit",  32'(Par_bit),   32'(m_par));
        check("state",    32'(fsm_state), 32'(m_busy ? SHIFT : IDLE));
    end

    // driver tasks
    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic load(input logic [7:0] d, input logic [3:0] l, input logic msb, input logic pt);
        Data       = d;
        Data_len   = l;
        MSB_first  = msb;
        Par_type   = pt;
        Data_valid = 1'b1;
        step();
        Data_valid = 1'b0;
    endtask

    // Strobes n bits with random gaps; seq holds the presented bits, first bit
    // in the most significant position. done_ok requires Ser_done only after
    // the n-th strobe.
    task automatic collect(input int n, input int gap_max, output logic [31:0] seq, output bit done_ok);
        seq     = 32'(Ser_data);
        done_ok = 1'b1;
        for (int i = 1; i <= n; i++) begin
            repeat ($urandom_range(gap_max, 0)) step();
            Ser_EN = 1'b1;
            step();
            Ser_EN = 1'b0;
            if (i < n) begin
                seq = (seq << 1) | 32'(Ser_data);
                if (Ser_done) done_ok = 1'b0;
            end else if (!Ser_done) begin
                done_ok = 1'b0;
            end
        end
    endtask

    initial begin
        logic [31:0] seq;
        bit          ok;

        Data = '0; Data_len = '0; MSB_first = 1'b0; Par_type = 1'b0;
        Data_valid = 1'b0; Ser_EN = 1'b0; Abort = 1'b0;
        Reset = 1'b0;
        repeat (3) @(negedge CLK);
        #1;
        check("rst_ready", 32'(Ready), 32'd1);
        check("rst_busy",  32'(Busy),  32'd0);
        check("rst_ser",   32'(Ser_data), 32'd0);
        check("rst_par",   32'(Par_bit),  32'd0);
        #2 Reset = 1'b1;
        step();

        // 0xA5 LSB-first, then 0x3C loaded in the Ser_done cycle
        load(8'hA5, 4'd8, 1'b0, 1'b0);
        check("a5_par", 32'(Par_bit), 32'd0);
        collect(8, 2, seq, ok);
        check("a5_bits", seq, 32'h0000_00A5);
        check("a5_done", 32'(ok), 32'd1);
        check("b2b_ready", 32'(Ready), 32'd1);
        load(8'h3C, 4'd8, 1'b0, 1'b0);
        check("b2b_busy", 32'(Busy), 32'd1);
        collect(8, 1, seq, ok);
        check("3c_bits", seq, 32'h0000_003C);
        check("3c_done", 32'(ok), 32'd1);
        step();
        check("3c_done_pulse", 32'(Ser_done), 32'd0);

        // len 5, MSB-first, odd parity
        load(8'h16, 4'd5, 1'b1, 1'b1);
        check("16_par", 32'(Par_bit), 32'd0);
        collect(5, 3, seq, ok);
        check("16_bits", seq, 32'h0000_0016);
        check("16_done", 32'(ok), 32'd1);
        step();

        // abort after the third strobe
        load(8'h96, 4'd8, 1'b0, 1'b1);
        repeat (3) begin
            Ser_EN = 1'b1;
            step();
            Ser_EN = 1'b0;
        end
        Abort = 1'b1;
        step();
        Abort = 1'b0;
        check("abort_ready", 32'(Ready), 32'd1);
        check("abort_ser",   32'(Ser_data), 32'd0);
        check("abort_done",  32'(Ser_done), 32'd0);
        check("abort_par",   32'(Par_bit), 32'd1);
        step();
        check("abort_done2", 32'(Ser_done), 32'd0);
        load(8'h96, 4'd8, 1'b0, 1'b1);
        collect(8, 1, seq, ok);
        check("96_bits", seq, 32'h0000_0069);
        check("96_done", 32'(ok), 32'd1);
        step();

        // reset mid-frame, then a len=0 frame
        load(8'hF0, 4'd8, 1'b1, 1'b0);
        repeat (2) begin
            Ser_EN = 1'b1;
            step();
            Ser_EN = 1'b0;
        end
        #2 Reset = 1'b0;
        #1;
        check("mrst_ready", 32'(Ready), 32'd1);
        check("mrst_busy",  32'(Busy),  32'd0);
        check("mrst_ser",   32'(Ser_data), 32'd0);
        check("mrst_done",  32'(Ser_done), 32'd0);
        check("mrst_par",   32'(Par_bit),  32'd0);
        @(negedge CLK);
        #2 Reset = 1'b1;
        step();
        check("mrst_done2", 32'(Ser_done), 32'd0);
        load(8'h5A, 4'd0, 1'b0, 1'b0);
        collect(8, 1, seq, ok);
        check("len0_bits", seq, 32'h0000_005A);
        check("len0_done", 32'(ok), 32'd1);
        step();

        // randomized traffic
        for (int c = 0; c < 1500; c++) begin
            Data       = 8'($urandom);
            Data_len   = 4'($urandom_range(15, 0));
            MSB_first  = 1'($urandom);
            Par_type   = 1'($urandom);
            Data_valid = ($urandom_range(3, 0) == 0);
            Ser_EN     = ($urandom_range(1, 0) == 0);
            Abort      = ($urandom_range(40, 0) == 0);
            step();
            if ($urandom_range(200, 0) == 0) begin
                #2 Reset = 1'b0;
                #3 Reset = 1'b1;
            end
        end
        Data_valid = 1'b0; Ser_EN = 1'b0; Abort = 1'b0;
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/frame_serializer.md
FRAME_SERIALIZER -- requirements
Module: frame_serializer

Interface
REQ-001 Parameter MAX_WIDTH, default 8, SHALL set the maximum frame payload width in bits (legal range 2..32).
REQ-002 Parameter LEN_W, default $clog2(MAX_WIDTH)+1, SHALL set the width of Data_len.
REQ-003 CLK  input  1  SHALL be the single clock; all state updates occur on its rising edge.
REQ-004 Reset  input  1  SHALL be the asynchronous, active-low reset.
REQ-005 Data  input  MAX_WIDTH  SHALL carry the parallel word; bit 0 is the LSB.
REQ-006 Data_len  input  LEN_W  SHALL give the number of bits to send (1..MAX_WIDTH); 0 or any value >MAX_WIDTH SHALL be treated as MAX_WIDTH.
REQ-007 MSB_first  input  1  SHALL select bit order: 0 sends Data[0] first; 1 sends Data[Data_len-1] first.
REQ-008 Par_type  input  1  SHALL select parity: 0 even, 1 odd.
REQ-009 Data_valid  input  1  SHALL request a load; it is sampled only when Ready=1.
REQ-010 Ser_EN  input  1  SHALL be the one-cycle bit-advance strobe (baud tick).
REQ-011 Abort  input  1  SHALL cancel any frame in progress.
REQ-012 Ready  output  1  SHALL be high exactly when the state is IDLE.
REQ-013 Busy  output  1  SHALL be high exactly when the state is SHIFT.
REQ-014 Ser_data  output  1  SHALL carry the current serial bit.
REQ-015 Ser_done  output  1  SHALL be a one-cycle pulse after the last bit completes.
REQ-016 Par_bit  output  1  SHALL carry the parity of the loaded bits, held until the next load.

Function
REQ-017 The FSM SHALL have two states, IDLE and SHIFT.
REQ-018 IDLE with Data_valid=1 and Abort=0 SHALL perform a load on that edge: latch the length-masked Data, latch Data_len (after REQ-006 clamping), MSB_first and Par_type, drive the first bit on Ser_data in the next cycle, set bit counter=1, and go to SHIFT.
REQ-019 At load, Par_bit SHALL become XOR(Data[len-1:0]) XOR Par_type.
REQ-020 SHIFT with Ser_EN=1 and counter<len SHALL present the next bit in the selected order and increment the counter.
REQ-021 SHIFT with Ser_EN=1 and counter==len SHALL go to IDLE, drive Ser_data=0, and assert Ser_done for exactly the next cycle.
REQ-022 SHIFT with Ser_EN=0 SHALL hold Ser_data and the counter.
REQ-023 Data_valid in SHIFT SHALL be ignored; the shift register SHALL NOT be modified.
REQ-024 In the Ser_done cycle Ready=1, so a Data_valid in that cycle SHALL load (back-to-back frames with zero gap).
REQ-025 Ser_EN in IDLE SHALL have no effect.
REQ-026 Abort=1 SHALL have priority over load and Ser_EN: next cycle IDLE, Ser_data=0, counter=0, no Ser_done; Par_bit keeps its value.
REQ-027 With len=1, the first Ser_EN after the load SHALL complete the frame.
REQ-028 The counter SHALL be LEN_W bits wide and SHALL never wrap.

Reset
REQ-029 Reset low SHALL immediately force: state IDLE, Ready=1, Busy=0, Ser_data=0, Ser_done=0, Par_bit=0, counter=0, shift register=0.
REQ-030 Reset asserted mid-frame SHALL discard the frame with no Ser_done pulse.

Structure
REQ-031 A shared package SHALL hold the state enum (IDLE, SHIFT) and the length-clamp function.
REQ-032 Parity SHALL be computed in one sub-module, ser_parity (masked XOR reduction, parameterised by MAX_WIDTH).

Verification
REQ-033 MAX_WIDTH=8, len=8, LSB-first, Data=0xA5, Par_type=0 -> Ser_data 1,0,1,0,0,1,0,1 on successive Ser_EN; Par_bit=0; one Ser_done pulse.
REQ-034 len=5, MSB_first=1, Data=0x16, Par_type=1 -> bits 1,0,1,1,0; Par_bit=0; Ser_done after the fifth Ser_EN.
REQ-035 Data_valid asserted in the Ser_done cycle with Data=0x3C -> new frame starts with zero idle cycles; second Ser_done 8 Ser_EN later.
REQ-036 Abort after the third Ser_EN -> IDLE next cycle, Ser_data=0, no Ser_done; the next load sends its full frame.
REQ-037 Reset pulsed mid-frame, and Data_len=0 (must send 8 bits) -> all outputs at REQ-029 values; frame discarded; the len=0 frame sends 8 bits.
